// File: rtl/mem_access_stage.sv
// Memory-access stage of the RV32I pipeline: drives the data-memory req/ack
// handshake, steers store lanes, extends load data and owns the MEM/WB register.
module mem_access_stage #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic [31:0] ex_alu_result,
    input  logic [31:0] ex_store_data,
    input  logic [4:0]  ex_rd,
    input  logic [2:0]  ex_funct3,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic        ex_reg_write,
    output logic        mem_stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output logic [31:0] wb_result,
    output logic [4:0]  wb_rd,
    output logic        wb_reg_write,
    output logic        misalign_err,
    output logic        bus_err
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [3:0]       be_q, be_d;
    logic             we_q, we_d;
    logic             load_q, load_d;
    logic [2:0]       funct3_q, funct3_d;
    logic [4:0]       rd_q, rd_d;
    logic             regw_q, regw_d;
    logic             wb_valid_q, wb_valid_d;
    logic [31:0]      wb_result_q, wb_result_d;
    logic [4:0]       wb_rd_q, wb_rd_d;
    logic             wb_reg_write_q, wb_reg_write_d;
    logic             misalign_q, misalign_d;
    logic             bus_err_q, bus_err_d;

    logic             memop_s;
    logic             misalign_s;
    logic             timeout_s;
    logic [31:0]      shifted_s;
    logic [31:0]      load_val_s;

    function automatic logic misaligned_f(input logic [2:0] f3, input logic [1:0] a);
        case (f3[1:0])
            2'b00:   misaligned_f = 1'b0;
            2'b01:   misaligned_f = a[0];
            2'b10:   misaligned_f = (a != 2'b00);
            default: misaligned_f = 1'b0;
        endcase
    endfunction

    assign memop_s    = ex_valid & (ex_mem_read | ex_mem_write);
    assign misalign_s = misaligned_f(ex_funct3, ex_alu_result[1:0]);
    assign timeout_s  = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign shifted_s  = dmem_rdata >> {addr_q[1:0], 3'b000};

    // Load extraction from the acknowledged read word
    always_comb begin
        load_val_s = 32'h0000_0000;
        case (funct3_q)
            3'b000:  load_val_s = {{24{shifted_s[7]}}, shifted_s[7:0]};
            3'b100:  load_val_s = {24'h00_0000, shifted_s[7:0]};
            3'b001:  load_val_s = {{16{shifted_s[15]}}, shifted_s[15:0]};
            3'b101:  load_val_s = {16'h0000, shifted_s[15:0]};
            3'b010:  load_val_s = dmem_rdata;
            default: load_val_s = 32'h0000_0000;
        endcase
    end

    // Next-state, capture and MEM/WB update logic
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        be_d           = be_q;
        we_d           = we_q;
        load_d         = load_q;
        funct3_d       = funct3_q;
        rd_d           = rd_q;
        regw_d         = regw_q;
        wb_valid_d     = wb_valid_q;
        wb_result_d    = wb_result_q;
        wb_rd_d        = wb_rd_q;
        wb_reg_write_d = wb_reg_write_q;
        misalign_d     = 1'b0;
        bus_err_d      = 1'b0;
        mem_stall      = 1'b0;
        case (state_q)
            IDLE: begin
                if (!memop_s) begin
                    wb_valid_d     = ex_valid;
                    wb_result_d    = ex_alu_result;
                    wb_rd_d        = ex_rd;
                    wb_reg_write_d = ex_reg_write & ex_valid;
                end else if (misalign_s) begin
                    wb_valid_d     = 1'b1;
                    wb_result_d    = ex_alu_result;
                    wb_rd_d        = ex_rd;
                    wb_reg_write_d = 1'b0;
                    misalign_d     = 1'b1;
                end else begin
                    mem_stall      = 1'b1;
                    state_d        = BUSY;
                    cnt_d          = '0;
                    addr_d         = ex_alu_result;
                    load_d         = ex_mem_read;
                    we_d           = ~ex_mem_read;
                    funct3_d       = ex_funct3;
                    rd_d           = ex_rd;
                    regw_d         = ex_reg_write;
                    wb_valid_d     = 1'b0;
                    wb_reg_write_d = 1'b0;
                    // Byte lanes follow the low address bits; data is replicated across lanes
                    case (ex_funct3)
                        3'b000: begin
                            be_d    = 4'b0001 << ex_alu_result[1:0];
                            wdata_d = {4{ex_store_data[7:0]}};
                        end
                        3'b001: begin
                            be_d    = 4'b0011 << ex_alu_result[1:0];
                            wdata_d = {2{ex_store_data[15:0]}};
                        end
                        3'b010: begin
                            be_d    = 4'b1111;
                            wdata_d = ex_store_data;
                        end
                        default: begin
                            be_d    = 4'b0000;
                            wdata_d = 32'h0000_0000;
                        end
                    endcase
                end
            end
            BUSY: begin
                if (dmem_ack) begin
                    state_d        = IDLE;
                    wb_valid_d     = 1'b1;
                    wb_rd_d        = rd_q;
                    wb_reg_write_d = regw_q & load_q;
                    wb_result_d    = load_q ? load_val_s : addr_q;
                end else if (timeout_s) begin
                    state_d        = IDLE;
                    wb_valid_d     = 1'b1;
                    wb_rd_d        = rd_q;
                    wb_reg_write_d = 1'b0;
                    wb_result_d    = addr_q;
                    bus_err_d      = 1'b1;
                end else begin
                    mem_stall      = 1'b1;
                    cnt_d          = cnt_q + CNT_W'(1);
                    wb_valid_d     = 1'b0;
                    wb_reg_write_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and pipeline registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            addr_q         <= 32'h0000_0000;
            wdata_q        <= 32'h0000_0000;
            be_q           <= 4'b0000;
            we_q           <= 1'b0;
            load_q         <= 1'b0;
            funct3_q       <= 3'b000;
            rd_q           <= 5'd0;
            regw_q         <= 1'b0;
            wb_valid_q     <= 1'b0;
            wb_result_q    <= 32'h0000_0000;
            wb_rd_q        <= 5'd0;
            wb_reg_write_q <= 1'b0;
            misalign_q     <= 1'b0;
            bus_err_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            be_q           <= be_d;
            we_q           <= we_d;
            load_q         <= load_d;
            funct3_q       <= funct3_d;
            rd_q           <= rd_d;
            regw_q         <= regw_d;
            wb_valid_q     <= wb_valid_d;
            wb_result_q    <= wb_result_d;
            wb_rd_q        <= wb_rd_d;
            wb_reg_write_q <= wb_reg_write_d;
            misalign_q     <= misalign_d;
            bus_err_q      <= bus_err_d;
        end
    end

    assign dmem_req     = (state_q == BUSY);
    assign dmem_we      = dmem_req & we_q;
    assign dmem_addr    = dmem_req ? {addr_q[31:2], 2'b00} : 32'h0000_0000;
    assign dmem_wdata   = dmem_req ? wdata_q : 32'h0000_0000;
    assign dmem_be      = dmem_req ? be_q : 4'b0000;
    assign wb_valid     = wb_valid_q;
    assign wb_result    = wb_result_q;
    assign wb_rd        = wb_rd_q;
    assign wb_reg_write = wb_reg_write_q;
    assign misalign_err = misalign_q;
    assign bus_err      = bus_err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: the stimulus pushes expected MEM/WB
// results computed from a plain-arithmetic memory model; a monitor pops them.
module tb_mem_access_stage;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic [31:0] ex_alu_result;
    logic [31:0] ex_store_data;
    logic [4:0]  ex_rd;
    logic [2:0]  ex_funct3;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic        ex_reg_write;
    logic        mem_stall;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        wb_valid;
    logic [31:0] wb_result;
    logic [4:0]  wb_rd;
    logic        wb_reg_write;
    logic        misalign_err;
    logic        bus_err;

    always #5 clk = ~clk;

    mem_access_stage #(.TIMEOUT_CYCLES(TIMEOUT), .CNT_W(5)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
        .ex_rd(ex_rd), .ex_funct3(ex_funct3), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write),
        .mem_stall(mem_stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .wb_valid(wb_valid), .wb_result(wb_result), .wb_rd(wb_rd),
        .wb_reg_write(wb_reg_write), .misalign_err(misalign_err), .bus_err(bus_err)
    );

    // kind: 0 normal completion, 1 misaligned, 2 timed out
    typedef struct {
        logic [31:0] result;
        logic [4:0]  rd;
        logic        regw;
        int          kind;
        bit          chk_data;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] word);
        logic [31:0] sh;
        logic [31:0] b;
        logic [31:0] h;
        sh = word >> (32'd8 * (addr % 32'd4));
        b  = sh % 32'd256;
        h  = sh % 32'd65536;
        case (f3)
            3'b000:  return (b >= 32'd128) ? b - 32'd256 : b;
            3'b100:  return b;
            3'b001:  return (h >= 32'd32768) ? h - 32'd65536 : h;
            3'b101:  return h;
            3'b010:  return word;
            default: return 32'd0;
        endcase
    endfunction

    function automatic int size_of(input logic [2:0] f3);
        return (f3[1:0] == 2'b00) ? 1 : ((f3[1:0] == 2'b01) ? 2 : 4);
    endfunction

    function automatic bit ref_misaligned(input logic [2:0] f3, input logic [31:0] addr);
        return (int'(addr % 32'd4) % size_of(f3)) != 0;
    endfunction

    function automatic logic [3:0] ref_be(input logic [2:0] f3, input logic [31:0] addr);
        int lanes;
        lanes = (1 << size_of(f3)) - 1;
        return 4'(lanes << (addr % 32'd4));
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] d);
        if (size_of(f3) == 1) return (d % 32'd256) * 32'h0101_0101;
        else if (size_of(f3) == 2) return (d % 32'd65536) * 32'h0001_0001;
        else return d;
    endfunction

    // Monitor: every MEM/WB presentation consumes one scoreboard entry
    always @(negedge clk) begin
        exp_t e;
        if (!rst && (wb_valid || misalign_err || bus_err)) begin
            if (exp_q.size() == 0) begin
                check("wb_unexpected_valid", 32'(wb_valid), 32'd0);
                check("wb_unexpected_misalign", 32'(misalign_err), 32'd0);
                check("wb_unexpected_buserr", 32'(bus_err), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("wb_valid", 32'(wb_valid), 32'd1);
                check("wb_reg_write", 32'(wb_reg_write), 32'(e.regw));
                check("misalign_err", 32'(misalign_err), 32'(e.kind == 1));
                check("bus_err", 32'(bus_err), 32'(e.kind == 2));
                if (e.chk_data) begin
                    check("wb_result", wb_result, e.result);
                    check("wb_rd", 32'(wb_rd), 32'(e.rd));
                end
            end
        end
    end

    task automatic do_op(input logic valid, input logic rd_en, input logic wr_en,
                         input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] data,
                         input logic regw, input logic [4:0] rd, input int wait_cyc,
                         input logic [31:0] rdata, output int stall_cnt, output int req_cnt);
        bit   memop;
        bit   done;
        exp_t e;
        memop     = valid && (rd_en || wr_en);
        stall_cnt = 0;
        req_cnt   = 0;
        @(posedge clk); #1;
        ex_valid = valid; ex_mem_read = rd_en; ex_mem_write = wr_en; ex_funct3 = f3;
        ex_alu_result = addr; ex_store_data = data; ex_reg_write = regw; ex_rd = rd;
        dmem_ack = 1'b0;
        if (!memop) begin
            if (valid) begin
                e = '{result: addr, rd: rd, regw: regw, kind: 0, chk_data: 1'b1};
                exp_q.push_back(e);
            end
            @(negedge clk);
            check("stall_nonmem", 32'(mem_stall), 32'd0);
            stall_cnt += int'(mem_stall);
        end else if (ref_misaligned(f3, addr)) begin
            e = '{result: 32'd0, rd: 5'd0, regw: 1'b0, kind: 1, chk_data: 1'b0};
            exp_q.push_back(e);
            @(negedge clk);
            check("stall_misalign", 32'(mem_stall), 32'd0);
            stall_cnt += int'(mem_stall);
        end else begin
            @(negedge clk);
            check("stall_accept", 32'(mem_stall), 32'd1);
            stall_cnt += int'(mem_stall);
            done = 1'b0;
            for (int k = 0; k < TIMEOUT && !done; k++) begin
                @(posedge clk); #1;
                ex_valid = 1'($urandom); ex_alu_result = $urandom; ex_store_data = $urandom;
                ex_mem_read = 1'($urandom); ex_mem_write = 1'($urandom);
                ex_funct3 = 3'($urandom); ex_rd = 5'($urandom); ex_reg_write = 1'($urandom);
                dmem_ack   = (k == wait_cyc);
                dmem_rdata = (k == wait_cyc) ? rdata : $urandom;
                @(negedge clk);
                req_cnt   += int'(dmem_req);
                stall_cnt += int'(mem_stall);
                check("req_busy", 32'(dmem_req), 32'd1);
                check("dmem_addr", dmem_addr, addr - (addr % 32'd4));
                check("dmem_we", 32'(dmem_we), 32'(!rd_en));
                if (!rd_en) begin
                    check("dmem_be", 32'(dmem_be), 32'(ref_be(f3, addr)));
                    check("dmem_wdata", dmem_wdata, ref_wdata(f3, data));
                end
                check("stall_busy", 32'(mem_stall), 32'(k != wait_cyc && k != TIMEOUT - 1));
                if (k == wait_cyc || k == TIMEOUT - 1) done = 1'b1;
            end
            if (wait_cyc < TIMEOUT) begin
                if (rd_en) e = '{result: ref_load(f3, addr, rdata), rd: rd, regw: regw, kind: 0, chk_data: 1'b1};
                else       e = '{result: addr, rd: rd, regw: 1'b0, kind: 0, chk_data: 1'b1};
            end else begin
                e = '{result: 32'd0, rd: 5'd0, regw: 1'b0, kind: 2, chk_data: 1'b0};
            end
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        ex_valid = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0; dmem_ack = 1'b0;
        @(negedge clk);
        check("req_after", 32'(dmem_req), 32'd0);
    endtask

    logic [2:0] ld_f3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    logic [2:0] st_f3 [3] = '{3'b000, 3'b001, 3'b010};

    initial begin
        int sc, rc, sel, wt;
        logic [2:0] f3;
        rst = 1'b1; ex_valid = 1'b0; ex_alu_result = 32'd0; ex_store_data = 32'd0;
        ex_rd = 5'd0; ex_funct3 = 3'd0; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
        ex_reg_write = 1'b0; dmem_ack = 1'b0; dmem_rdata = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req", 32'(dmem_req), 32'd0);
        check("rst_stall", 32'(mem_stall), 32'd0);
        check("rst_wb_valid", 32'(wb_valid), 32'd0);
        check("rst_wb_result", wb_result, 32'd0);
        check("rst_wb_regw", 32'(wb_reg_write), 32'd0);
        check("rst_errs", 32'({misalign_err, bus_err}), 32'd0);
        check("rst_dmem", dmem_addr | dmem_wdata | 32'(dmem_be) | 32'(dmem_we), 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        do_op(1'b1, 1'b0, 1'b0, 3'b000, 32'h0000_1234, 32'd0, 1'b1, 5'd5, 0, 32'd0, sc, rc);
        check("add_stall_count", 32'(sc), 32'd0);
        do_op(1'b1, 1'b0, 1'b0, 3'b000, 32'hCAFE_0000, 32'd0, 1'b1, 5'd0, 0, 32'd0, sc, rc);
        do_op(1'b1, 1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'd0, 1'b1, 5'd7, 3, 32'h80AA_BBCC, sc, rc);
        check("lb_stall_count", 32'(sc), 32'd4);
        do_op(1'b1, 1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'h0000_BEEF, 1'b0, 5'd0, 0, 32'd0, sc, rc);
        check("sh_req_count", 32'(rc), 32'd1);
        do_op(1'b1, 1'b1, 1'b0, 3'b010, 32'h0000_0301, 32'd0, 1'b1, 5'd9, 0, 32'd0, sc, rc);
        check("lw_mis_req_count", 32'(rc), 32'd0);
        do_op(1'b1, 1'b1, 1'b0, 3'b101, 32'h0000_0400, 32'd0, 1'b1, 5'd3, 100, 32'd0, sc, rc);
        check("lhu_to_req_count", 32'(rc), 32'(TIMEOUT));
        check("lhu_to_stall_count", 32'(sc), 32'(TIMEOUT));
        do_op(1'b1, 1'b1, 1'b1, 3'b100, 32'h0000_0602, 32'd0, 1'b1, 5'd11, 1, 32'h00F0_0000, sc, rc);

        // Reset in the middle of an outstanding load: no write-back, late ack ignored
        @(posedge clk); #1;
        ex_valid = 1'b1; ex_mem_read = 1'b1; ex_funct3 = 3'b010; ex_alu_result = 32'h0000_0500;
        ex_rd = 5'd4; ex_reg_write = 1'b1;
        @(posedge clk); #1;
        ex_valid = 1'b0; ex_mem_read = 1'b0; rst = 1'b1;
        @(negedge clk);
        check("rstbusy_req_before", 32'(dmem_req), 32'd1);
        @(negedge clk);
        check("rstbusy_req", 32'(dmem_req), 32'd0);
        check("rstbusy_wb_valid", 32'(wb_valid), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; dmem_ack = 1'b1; dmem_rdata = 32'h1234_5678;
        @(posedge clk); #1 dmem_ack = 1'b0;
        @(negedge clk);
        check("late_ack_wb_valid", 32'(wb_valid), 32'd0);
        check("late_ack_wb_regw", 32'(wb_reg_write), 32'd0);

        for (int i = 0; i < 150; i++) begin
            sel = $urandom_range(0, 3);
            wt  = ($urandom_range(0, 9) == 0) ? 20 : $urandom_range(0, 4);
            f3  = (sel == 2) ? st_f3[$urandom_range(0, 2)] : ld_f3[$urandom_range(0, 4)];
            do_op(1'($urandom_range(0, 9) != 0), (sel == 1 || sel == 3), (sel == 2 || sel == 3),
                  f3, $urandom, $urandom, 1'($urandom), 5'($urandom), wt, $urandom, sc, rc);
        end

        repeat (3) @(posedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
